// File: rtl/wide_instruction_queue.sv
// wide_instruction_queue
//   Multi-lane circular instruction queue between fetch and decode. Up to ENQ_W
//   instructions are written per cycle at the tail. Up to DEQ_W instructions are
//   presented at the head and consumed per cycle. The queue holds DEPTH entries.
//
// Optional feature: define WIQ_STATS_EN to add two 32-bit statistics counters:
//   stat_enq_total    instructions accepted
//   stat_stall_cycles cycles with an offer while enq_ready was low (flush cycles excluded)
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   flush                drop all queued entries (branch mispredict)
//   enq_num              lanes offered this cycle (lanes 0..enq_num-1), clamped to ENQ_W
//   enq_instr/enq_pc     per-lane instruction / PC, lane i at [32i+31:32i]
//   enq_ready            room for a full ENQ_W-wide write, from registered count only
//   deq_valid            lane i holds entry head+i
//   deq_instr/deq_pc     per-lane instruction / PC at head+i, combinational from storage
//   deq_take             head entries consumed this cycle, clamped to min(count, DEQ_W)
//   count, empty, full   occupancy status
module wide_instruction_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ENQ_W = 2,
  parameter int unsigned DEQ_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [$clog2(ENQ_W+1)-1:0]   enq_num,
  input  logic [ENQ_W*32-1:0]          enq_instr,
  input  logic [ENQ_W*32-1:0]          enq_pc,
  output logic                         enq_ready,
  output logic [DEQ_W-1:0]             deq_valid,
  output logic [DEQ_W*32-1:0]          deq_instr,
  output logic [DEQ_W*32-1:0]          deq_pc,
  input  logic [$clog2(DEQ_W+1)-1:0]   deq_take,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
`ifdef WIQ_STATS_EN
  ,
  output logic [31:0]                  stat_enq_total,
  output logic [31:0]                  stat_stall_cycles
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned EnqNW = $clog2(ENQ_W + 1);
  localparam int unsigned DeqNW = $clog2(DEQ_W + 1);

  // Storage is never cleared; validity is tracked purely by head/count.
  logic [31:0] instr_q [DEPTH];
  logic [31:0] pc_q    [DEPTH];

  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;

  logic [EnqNW-1:0] enq_clamp;
  logic [EnqNW-1:0] enq_acc;
  logic [DeqNW-1:0] take_clamp;
  logic [CntW-1:0]  take_ext;
  logic [CntW-1:0]  eff_take;

  // Ready reflects only registered occupancy: slots freed by a same-cycle take
  // are not credited, keeping this path off the consumer's combinational logic.
  assign enq_ready = ((CntW+1)'(count_q) + (CntW+1)'(ENQ_W)) <= (CntW+1)'(DEPTH);

  always_comb begin
    enq_clamp = (enq_num > EnqNW'(ENQ_W)) ? EnqNW'(ENQ_W) : enq_num;
    // Whole offer is accepted or whole offer is dropped.
    enq_acc = (enq_ready && !flush) ? enq_clamp : '0;

    take_clamp = (deq_take > DeqNW'(DEQ_W)) ? DeqNW'(DEQ_W) : deq_take;
    take_ext   = CntW'(take_clamp);
    eff_take   = flush ? '0 : ((take_ext > count_q) ? count_q : take_ext);

    head_d  = head_q + PtrW'(eff_take);
    tail_d  = tail_q + PtrW'(enq_acc);
    count_d = count_q + CntW'(enq_acc) - eff_take;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Data write; enq_acc is already zero under flush. A reset cycle may write
  // storage harmlessly since pointers and count are cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(ENQ_W); i++) begin
      if (EnqNW'(i) < enq_acc) begin
        instr_q[tail_q + PtrW'(i)] <= enq_instr[32*i +: 32];
        pc_q[tail_q + PtrW'(i)]    <= enq_pc[32*i +: 32];
      end
    end
  end

  always_comb begin
    deq_valid = '0;
    deq_instr = '0;
    deq_pc    = '0;
    for (int i = 0; i < int'(DEQ_W); i++) begin
      deq_valid[i]        = count_q > CntW'(i);
      deq_instr[32*i +: 32] = instr_q[head_q + PtrW'(i)];
      deq_pc[32*i +: 32]    = pc_q[head_q + PtrW'(i)];
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

`ifdef WIQ_STATS_EN
  logic [31:0] stat_enq_total_q;
  logic [31:0] stat_stall_cycles_q;

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_enq_total_q    <= '0;
      stat_stall_cycles_q <= '0;
    end else begin
      stat_enq_total_q <= stat_enq_total_q + 32'(enq_acc);
      if ((enq_num != '0) && !enq_ready && !flush) begin
        stat_stall_cycles_q <= stat_stall_cycles_q + 32'd1;
      end
    end
  end

  assign stat_enq_total    = stat_enq_total_q;
  assign stat_stall_cycles = stat_stall_cycles_q;
`endif

endmodule

// File: tb/tb_wide_instruction_queue.sv
// Directed bench for wide_instruction_queue at default parameters
// (DEPTH=16, ENQ_W=2, DEQ_W=2). Define WIQ_STATS_EN to also check statistics.
module tb_wide_instruction_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  enq_num;
  logic [63:0] enq_instr;
  logic [63:0] enq_pc;
  logic        enq_ready;
  logic [1:0]  deq_valid;
  logic [63:0] deq_instr;
  logic [63:0] deq_pc;
  logic [1:0]  deq_take;
  logic [4:0]  count;
  logic        empty;
  logic        full;
`ifdef WIQ_STATS_EN
  logic [31:0] stat_enq_total;
  logic [31:0] stat_stall_cycles;
`endif

  int n_total;
  int n_bad;

  wide_instruction_queue dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_num   (enq_num),
    .enq_instr (enq_instr),
    .enq_pc    (enq_pc),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_instr (deq_instr),
    .deq_pc    (deq_pc),
    .deq_take  (deq_take),
    .count     (count),
    .empty     (empty),
    .full      (full)
`ifdef WIQ_STATS_EN
    ,
    .stat_enq_total    (stat_enq_total),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int n, input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1);
    enq_num   = 2'(n);
    enq_instr = {i1, i0};
    enq_pc    = {p1, p0};
  endtask

  task automatic idle();
    enq_num  = 2'd0;
    deq_take = 2'd0;
    flush    = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad = 0;
    rst = 1'b1;
    flush = 1'b0;
    enq_num = '0;
    enq_instr = '0;
    enq_pc = '0;
    deq_take = '0;
    tick();
    tick();
    rst = 1'b0;

    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_empty", 64'(empty), 64'd1);
    check_eq("rst_full", 64'(full), 64'd0);
    check_eq("rst_ready", 64'(enq_ready), 64'd1);
    check_eq("rst_valid", 64'(deq_valid), 64'd0);
`ifdef WIQ_STATS_EN
    check_eq("rst_stat_tot", 64'(stat_enq_total), 64'd0);
`endif

    // Two-lane enqueue, visible the next cycle (head=0, tail=2).
    offer(2, 32'hAAAA_0001, 32'h100, 32'hBBBB_0002, 32'h104);
    tick();
    idle();
    check_eq("ab_count", 64'(count), 64'd2);
    check_eq("ab_valid", 64'(deq_valid), 64'd3);
    check_eq("ab_l0_instr", 64'(deq_instr[31:0]), 64'hAAAA_0001);
    check_eq("ab_l0_pc", 64'(deq_pc[31:0]), 64'h100);
    check_eq("ab_l1_instr", 64'(deq_instr[63:32]), 64'hBBBB_0002);
    check_eq("ab_l1_pc", 64'(deq_pc[63:32]), 64'h104);

    // Bring count to 3, then take 2 while enqueueing 2.
    offer(1, 32'hCCCC_0003, 32'h108, 32'h0, 32'h0);
    tick();
    check_eq("c_count", 64'(count), 64'd3);
    offer(2, 32'hDDDD_0004, 32'h10C, 32'hEEEE_0005, 32'h110);
    deq_take = 2'd2;
    tick();
    idle();
    check_eq("mix_count", 64'(count), 64'd3);
    check_eq("mix_l0_instr", 64'(deq_instr[31:0]), 64'hCCCC_0003);
    check_eq("mix_l0_pc", 64'(deq_pc[31:0]), 64'h108);
    check_eq("mix_l1_instr", 64'(deq_instr[63:32]), 64'hDDDD_0004);

    // Take 2 leaves E alone; take 2 again with count=1 advances head by one.
    deq_take = 2'd2;
    tick();
    check_eq("take_count1", 64'(count), 64'd1);
    check_eq("take_l0_instr", 64'(deq_instr[31:0]), 64'hEEEE_0005);
    check_eq("take_valid1", 64'(deq_valid), 64'd1);
    tick();
    idle();
    check_eq("over_take_count", 64'(count), 64'd0);
    check_eq("over_take_empty", 64'(empty), 64'd1);
    offer(1, 32'hFFFF_0006, 32'h114, 32'h0, 32'h0);
    tick();
    idle();
    check_eq("f_count", 64'(count), 64'd1);
    check_eq("f_l0_instr", 64'(deq_instr[31:0]), 64'hFFFF_0006);
    check_eq("f_l0_pc", 64'(deq_pc[31:0]), 64'h114);
    flush = 1'b1;
    tick();
    idle();
    check_eq("flush1_count", 64'(count), 64'd0);

    // Fill two per cycle for seven cycles.
    for (int k = 0; k < 7; k++) begin
      offer(2, 32'h1000_0000 + 32'(2*k), 32'h2000 + 32'(8*k),
               32'h1000_0001 + 32'(2*k), 32'h2004 + 32'(8*k));
      tick();
    end
    idle();
    check_eq("fill_count", 64'(count), 64'd14);
    check_eq("fill_ready14", 64'(enq_ready), 64'd1);
    check_eq("fill_l0_instr", 64'(deq_instr[31:0]), 64'h1000_0000);
    check_eq("fill_l1_pc", 64'(deq_pc[63:32]), 64'h2004);
    offer(1, 32'h1000_000E, 32'h2038, 32'h0, 32'h0);
    tick();
    check_eq("c15_count", 64'(count), 64'd15);
    check_eq("c15_ready", 64'(enq_ready), 64'd0);
    check_eq("c15_full", 64'(full), 64'd0);
    offer(2, 32'hDEAD_0000, 32'h0, 32'hDEAD_0001, 32'h4);
    tick();
    check_eq("drop_count", 64'(count), 64'd15);
`ifdef WIQ_STATS_EN
    check_eq("stall_one", 64'(stat_stall_cycles), 64'd1);
`endif
    // Freed slot this cycle is not credited: offer still dropped.
    deq_take = 2'd1;
    tick();
    idle();
    check_eq("take1_count", 64'(count), 64'd14);
    check_eq("take1_ready", 64'(enq_ready), 64'd1);
    check_eq("take1_l0_instr", 64'(deq_instr[31:0]), 64'h1000_0001);
    offer(2, 32'h1000_000F, 32'h203C, 32'h1000_0010, 32'h2040);
    tick();
    idle();
    check_eq("c16_count", 64'(count), 64'd16);
    check_eq("c16_full", 64'(full), 64'd1);
    check_eq("c16_ready", 64'(enq_ready), 64'd0);
    // Flush while full with an offer pending: not a stall cycle.
    flush = 1'b1;
    offer(2, 32'hDEAD_0002, 32'h0, 32'hDEAD_0003, 32'h4);
    tick();
    idle();
    check_eq("flush2_count", 64'(count), 64'd0);
    check_eq("flush2_valid", 64'(deq_valid), 64'd0);
`ifdef WIQ_STATS_EN
    check_eq("stall_flush", 64'(stat_stall_cycles), 64'd2);
    check_eq("tot_23", 64'(stat_enq_total), 64'd23);
`endif

    // enq_num=3 is treated as 2.
    offer(3, 32'h3000_0000, 32'h3000, 32'h3000_0001, 32'h3004);
    tick();
    idle();
    check_eq("clamp_count", 64'(count), 64'd2);
    check_eq("clamp_l1_instr", 64'(deq_instr[63:32]), 64'h3000_0001);
    for (int k = 0; k < 3; k++) begin
      offer(2, 32'h3100_0000 + 32'(k), 32'h0, 32'h3200_0000 + 32'(k), 32'h0);
      tick();
    end
    offer(1, 32'h3300_0000, 32'h0, 32'h0, 32'h0);
    tick();
    idle();
    check_eq("c9_count", 64'(count), 64'd9);
    flush = 1'b1;
    offer(2, 32'hDEAD_0004, 32'h0, 32'hDEAD_0005, 32'h4);
    deq_take = 2'd2;
    tick();
    idle();
    check_eq("flush3_count", 64'(count), 64'd0);
    check_eq("flush3_empty", 64'(empty), 64'd1);
    check_eq("flush3_valid", 64'(deq_valid), 64'd0);
`ifdef WIQ_STATS_EN
    check_eq("flush3_tot", 64'(stat_enq_total), 64'd32);
`endif

    // Move head and tail to 14, then wrap through the end of storage.
    for (int k = 0; k < 7; k++) begin
      offer(2, 32'h0, 32'h0, 32'h0, 32'h0);
      tick();
    end
    idle();
    deq_take = 2'd2;
    for (int k = 0; k < 7; k++) tick();
    idle();
    check_eq("wrap_pre_count", 64'(count), 64'd0);
    offer(2, 32'h5000_0000, 32'h5000, 32'h5000_0001, 32'h5004);
    tick();
    offer(2, 32'h5000_0002, 32'h5008, 32'h5000_0003, 32'h500C);
    tick();
    idle();
    check_eq("wrap_count", 64'(count), 64'd4);
    check_eq("wrap_l0_instr", 64'(deq_instr[31:0]), 64'h5000_0000);
    check_eq("wrap_l1_instr", 64'(deq_instr[63:32]), 64'h5000_0001);
    deq_take = 2'd2;
    tick();
    check_eq("wrap_l0_after", 64'(deq_instr[31:0]), 64'h5000_0002);
    check_eq("wrap_l1_pc_after", 64'(deq_pc[63:32]), 64'h500C);
    tick();
    idle();
    check_eq("wrap_empty", 64'(empty), 64'd1);
`ifdef WIQ_STATS_EN
    check_eq("tot_50", 64'(stat_enq_total), 64'd50);
    check_eq("stall_2", 64'(stat_stall_cycles), 64'd2);
`endif

    // Reset wins over simultaneous enqueue and flush.
    offer(2, 32'h6000_0000, 32'h0, 32'h6000_0001, 32'h0);
    tick();
    check_eq("pre_rst_count", 64'(count), 64'd2);
    rst = 1'b1;
    flush = 1'b1;
    deq_take = 2'd1;
    tick();
    rst = 1'b0;
    idle();
    check_eq("rst2_count", 64'(count), 64'd0);
    check_eq("rst2_ready", 64'(enq_ready), 64'd1);
`ifdef WIQ_STATS_EN
    check_eq("rst2_stat_tot", 64'(stat_enq_total), 64'd0);
    check_eq("rst2_stat_stall", 64'(stat_stall_cycles), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
